access_controller: RTL
======================

Name: access_controller

Overview:
- Keypad access FSM directly upstream of the UART status string sender.
- Collects BCD digits and checks them against a code on Enter.
- Drives the lock, alarm and lockout outputs.
- Publishes one status event per outcome (OPEN / WRONG / LOCK) on o_status/o_trigger, handshaking with the sender's busy flag so that no event is lost or corrupted mid-string.

Parameters:
CODE_LEN, 4, number of digits in the access code (1..8)
CODE, 32'h0000_1234, expected code, 4 bits BCD per digit, last-entered digit in bits [3:0]
MAX_TRIES, 3, consecutive wrong entries that trigger lockout (1..15)
LOCKOUT_CYCLES, 1_000_000_000, lockout duration in i_clk cycles (10 s at 100 MHz), 32-bit

Ports:
i_clk  in  1  system clock, 100 MHz
i_rst  in  1  synchronous, active-high reset
i_key_valid  in  1  one-cycle strobe, i_key_digit valid
i_key_digit  in  4  BCD digit 0..9; values 10..15 ignored
i_enter  in  1  one-cycle strobe, submit entered code
i_lock  in  1  one-cycle strobe, relock when open
i_sender_busy  in  1  busy flag from the string sender
o_status  out  3  status code: 001 OPEN, 010 WRONG, 100 LOCK
o_trigger  out  1  one-cycle start strobe to the sender
o_unlocked  out  1  high while in S_OPEN
o_alarm  out  1  high while in S_LOCKOUT
o_tries  out  4  current consecutive wrong count

Behaviour:
- Reset (i_clk edge with i_rst=1):
  - Main FSM goes to S_LOCKED; report FSM goes to R_IDLE.
  - Digit buffer, digit count, tries, lockout counter and pending flag are cleared.
  - Outputs: o_status=000, o_trigger=0, o_unlocked=0, o_alarm=0, o_tries=0.
  - Reset mid-report abandons the event; nothing is retried.
- Main FSM, S_LOCKED:
  - i_key_valid with digit<=9 shifts the digit into the buffer (buffer <= {buf[27:0], digit}). Count increments, saturating at CODE_LEN; digits beyond CODE_LEN still shift in, so the last CODE_LEN digits are compared.
  - i_enter:
    - Match when count==CODE_LEN and buf[4*CODE_LEN-1:0]==CODE[4*CODE_LEN-1:0]. Result: S_OPEN, tries<=0, event OPEN.
    - Otherwise tries+1 and event WRONG. If tries+1==MAX_TRIES, go to S_LOCKOUT with counter<=LOCKOUT_CYCLES-1.
    - In all cases the buffer and count are cleared.
  - i_enter and i_key_valid in the same cycle: i_enter wins and the digit is discarded.
- Main FSM, S_OPEN:
  - o_unlocked=1. Keys and i_enter are ignored.
  - i_lock: go to S_LOCKED, event LOCK.
- Main FSM, S_LOCKOUT:
  - o_alarm=1. All inputs are ignored.
  - The counter decrements each cycle. At 0: go to S_LOCKED, tries<=0, no event.
- i_lock outside S_OPEN is ignored.
- Event latency: o_trigger goes high at the earliest 1 cycle after the registered strobe edge.
- Report FSM (exactly one event in flight):
  - R_IDLE: if an event is pending and i_sender_busy=0, load o_status, clear pending, go to R_PULSE.
  - R_PULSE: o_trigger=1 for exactly one cycle, then go to R_ACK.
  - R_ACK: wait for i_sender_busy=1, then go to R_DONE. Timeout after 15 cycles returns to R_IDLE and the event is dropped.
  - R_DONE: wait for i_sender_busy=0, then go to R_IDLE.
  - o_status holds its value from load until the next load, and is never changed while the sender is busy.
- Pending slot: one entry. A new event while a report is in flight or pending overwrites the pending code (newest wins). An event generated in the same cycle as the R_IDLE load is captured as pending, not lost.
- o_trigger is never high on two consecutive cycles. It is low at least 1 cycle between pulses, which the sender's edge detector requires.

Decomposition:
- Shared package: the status codes ST_OPEN=3'b001, ST_WRONG=3'b010, ST_LOCK=3'b100. The sender uses the same encodings.
- Shared package also holds the main-state and report-state localparams.
- Natural sub-module: status_reporter. It contains the report FSM, the pending slot and the ack timeout, with inputs event_valid/event_code/i_sender_busy and outputs o_status/o_trigger.
- The digit buffer and lockout counter stay in the top level.

Test Plan:
- Reset, then keys 1,2,3,4 and enter, sender idle → o_trigger pulse with o_status=001; o_unlocked=1; o_tries=0.
- Keys 1,2,3,5 + enter three times, sender modelled busy 20 cycles after each trigger → three triggers with o_status=010; o_alarm=1 after the 3rd; o_tries=3; LOCKOUT_CYCLES=50 → o_alarm drops after 50 cycles with no trigger, o_tries=0.
- Open, then i_lock while the sender is busy from the OPEN report → LOCK held pending; trigger with o_status=100 only after busy falls; o_status stays 001 throughout the busy window.
- Keys 9,1,2,3,4 + enter → OPEN (last 4 digits match); keys 1,2,3 + enter → WRONG (short entry); key digit 12 → ignored, count unchanged.
- Same-cycle i_key_valid(4) and i_enter after 1,2,3 → WRONG; the buffer is empty afterwards.
- i_rst asserted while in R_DONE with the sender busy → all outputs reset next edge; no further trigger after busy falls. Sender never asserts busy → event dropped after 15 cycles and o_trigger stays 0.

Source files
------------

// File: rtl/access_controller_pkg.sv
// Shared encodings for the keypad access controller and its status reporter.
// The status codes match the encoding the UART string sender decodes.
package access_controller_pkg;

  localparam logic [2:0] ST_NONE  = 3'b000;
  localparam logic [2:0] ST_OPEN  = 3'b001;
  localparam logic [2:0] ST_WRONG = 3'b010;
  localparam logic [2:0] ST_LOCK  = 3'b100;

  // Cycles the reporter waits in R_ACK for the sender to raise busy.
  localparam logic [3:0] ACK_TIMEOUT = 4'd15;

  typedef enum logic [1:0] {
    S_LOCKED  = 2'd0,
    S_OPEN    = 2'd1,
    S_LOCKOUT = 2'd2
  } main_state_t;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_PULSE = 2'd1,
    R_ACK   = 2'd2,
    R_DONE  = 2'd3
  } rep_state_t;

endpackage

// File: rtl/access_controller_status_reporter.sv
// Status event reporter: one-entry pending slot feeding a report FSM that
// hands one status code at a time to the string sender.
//
// state   | meaning
// R_IDLE  | waiting for a pending event and an idle sender
// R_PULSE | status loaded, start strobe high this cycle
// R_ACK   | waiting for the sender to go busy (bounded by ACK_TIMEOUT)
// R_DONE  | waiting for the sender to finish the string
module status_reporter
  import access_controller_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       event_valid,
  input  logic [2:0] event_code,
  input  logic       i_sender_busy,
  output logic [2:0] o_status,
  output logic       o_trigger
);

  rep_state_t state, state_n;
  logic       pending, pending_n;
  logic [2:0] pend_code, pend_code_n;
  logic [2:0] status, status_n;
  logic [3:0] tmo, tmo_n;

  // Register the report FSM, pending slot, published status and ack timer.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= R_IDLE;
      pending   <= 1'b0;
      pend_code <= ST_NONE;
      status    <= ST_NONE;
      tmo       <= '0;
    end else begin
      state     <= state_n;
      pending   <= pending_n;
      pend_code <= pend_code_n;
      status    <= status_n;
      tmo       <= tmo_n;
    end
  end

  // Next-state logic; a fresh event always lands in the pending slot, even in
  // the cycle the previous one is being loaded, so nothing is lost.
  always_comb begin
    state_n     = state;
    pending_n   = pending;
    pend_code_n = pend_code;
    status_n    = status;
    tmo_n       = tmo;
    case (state)
      R_IDLE: begin
        if (pending && !i_sender_busy) begin
          status_n  = pend_code;
          pending_n = 1'b0;
          state_n   = R_PULSE;
        end
      end
      R_PULSE: begin
        tmo_n   = '0;
        state_n = R_ACK;
      end
      R_ACK: begin
        if (i_sender_busy) begin
          state_n = R_DONE;
        end else if (tmo == ACK_TIMEOUT - 4'd1) begin
          state_n = R_IDLE;
        end else begin
          tmo_n = tmo + 4'd1;
        end
      end
      R_DONE: begin
        if (!i_sender_busy) state_n = R_IDLE;
      end
      default: state_n = R_IDLE;
    endcase
    if (event_valid) begin
      pending_n   = 1'b1;
      pend_code_n = event_code;
    end
  end

  assign o_status  = status;
  assign o_trigger = (state == R_PULSE);

endmodule

// File: rtl/access_controller.sv
// Keypad access controller: collects BCD digits, checks them on Enter, drives
// lock/alarm/lockout and posts one status event per outcome to the reporter.
//
// state     | meaning
// S_LOCKED  | collecting digits, Enter checks the code
// S_OPEN    | door unlocked until i_lock
// S_LOCKOUT | too many wrong entries, alarm on, inputs ignored
module access_controller
  import access_controller_pkg::*;
#(
  parameter int          CODE_LEN       = 4,
  parameter logic [31:0] CODE           = 32'h0000_1234,
  parameter int          MAX_TRIES      = 3,
  parameter logic [31:0] LOCKOUT_CYCLES = 32'd1_000_000_000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_key_valid,
  input  logic [3:0] i_key_digit,
  input  logic       i_enter,
  input  logic       i_lock,
  input  logic       i_sender_busy,
  output logic [2:0] o_status,
  output logic       o_trigger,
  output logic       o_unlocked,
  output logic       o_alarm,
  output logic [3:0] o_tries
);

  localparam logic [31:0] CODE_MASK  = 32'hFFFF_FFFF >> (32 - 4 * CODE_LEN);
  localparam logic [3:0]  CODE_LEN_W = 4'(CODE_LEN);
  localparam logic [3:0]  TRIES_MAX  = 4'(MAX_TRIES);

  main_state_t state, state_n;
  logic [31:0] dbuf, dbuf_n;
  logic [3:0]  dcount, dcount_n;
  logic [3:0]  tries, tries_n;
  logic [31:0] lock_cnt, lock_cnt_n;
  logic        event_valid;
  logic [2:0]  event_code;
  logic        code_match;
  logic [3:0]  tries_inc;

  assign code_match = (dcount == CODE_LEN_W) && ((dbuf & CODE_MASK) == (CODE & CODE_MASK));
  assign tries_inc  = tries + 4'd1;

  // Register the main FSM, digit buffer, try counter and lockout timer.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= S_LOCKED;
      dbuf     <= '0;
      dcount   <= '0;
      tries    <= '0;
      lock_cnt <= '0;
    end else begin
      state    <= state_n;
      dbuf     <= dbuf_n;
      dcount   <= dcount_n;
      tries    <= tries_n;
      lock_cnt <= lock_cnt_n;
    end
  end

  // Next-state and event generation; Enter takes priority over a same-cycle key.
  always_comb begin
    state_n     = state;
    dbuf_n      = dbuf;
    dcount_n    = dcount;
    tries_n     = tries;
    lock_cnt_n  = lock_cnt;
    event_valid = 1'b0;
    event_code  = ST_NONE;
    case (state)
      S_LOCKED: begin
        if (i_enter) begin
          dbuf_n      = '0;
          dcount_n    = '0;
          event_valid = 1'b1;
          if (code_match) begin
            state_n    = S_OPEN;
            tries_n    = '0;
            event_code = ST_OPEN;
          end else begin
            tries_n    = tries_inc;
            event_code = ST_WRONG;
            if (tries_inc == TRIES_MAX) begin
              state_n    = S_LOCKOUT;
              lock_cnt_n = LOCKOUT_CYCLES - 32'd1;
            end
          end
        end else if (i_key_valid && (i_key_digit <= 4'd9)) begin
          dbuf_n = {dbuf[27:0], i_key_digit};
          if (dcount != CODE_LEN_W) dcount_n = dcount + 4'd1;
        end
      end
      S_OPEN: begin
        if (i_lock) begin
          state_n     = S_LOCKED;
          event_valid = 1'b1;
          event_code  = ST_LOCK;
        end
      end
      S_LOCKOUT: begin
        if (lock_cnt == 32'd0) begin
          state_n = S_LOCKED;
          tries_n = '0;
        end else begin
          lock_cnt_n = lock_cnt - 32'd1;
        end
      end
      default: state_n = S_LOCKED;
    endcase
  end

  status_reporter u_reporter (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .event_valid   (event_valid),
    .event_code    (event_code),
    .i_sender_busy (i_sender_busy),
    .o_status      (o_status),
    .o_trigger     (o_trigger)
  );

  assign o_unlocked = (state == S_OPEN);
  assign o_alarm    = (state == S_LOCKOUT);
  assign o_tries    = tries;

endmodule
